// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame-format word,
// bit-timer width, and small frame-format helper functions.
package uart_pkg;

  // Width of the bit-time counter and of the k terminal-count input.
  localparam int unsigned TIMER_W = 19;

  // Sample shift register width: up to 8 data + parity + stop.
  localparam int unsigned SR_W = 10;

  // Receiver state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  // Frame format word {eight, parity_en, ohel}, also used by transmit.
  typedef struct packed {
    logic eight;      // 1 = 8 data bits, 0 = 7 data bits
    logic parity_en;  // parity bit follows the data bits
    logic ohel;       // 1 = odd parity, 0 = even parity
  } frame_fmt_t;

  // Number of bit samples after the start bit: data + parity + stop.
  function automatic logic [3:0] fmt_samples(input frame_fmt_t fmt);
    return 4'd8 + {3'd0, fmt.eight} + {3'd0, fmt.parity_en};
  endfunction

  // Parity bit a correct transmitter sends for the given data bits.
  function automatic logic expected_parity(input logic [7:0] d, input frame_fmt_t fmt);
    logic [7:0] w_bits;
    w_bits = fmt.eight ? d : {1'b0, d[6:0]};
    return (^w_bits) ^ fmt.ohel;
  endfunction

endpackage

// File: rtl/receive_if.sv
// Host/line-side bundle of the UART receiver: serial input, static frame
// configuration, host read strobe, and received byte plus status.
interface receive_if;
  import uart_pkg::*;

  logic               rx;
  logic [TIMER_W-1:0] k;
  logic               eight;
  logic               parity_en;
  logic               ohel;
  logic               read;
  logic [7:0]         data;
  logic               rxrdy;
  logic               perr;
  logic               ferr;
  logic               ovf;

  // Host / line driver side.
  modport master (
    output rx, k, eight, parity_en, ohel, read,
    input  data, rxrdy, perr, ferr, ovf
  );

  // Receiver side.
  modport slave (
    input  rx, k, eight, parity_en, ohel, read,
    output data, rxrdy, perr, ferr, ovf
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts 0..term while enabled, where term is k or k>>1,
// and pulses o_tc on the terminal cycle before reloading 0. Held at 0 when
// disabled so every enable starts a fresh interval.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_half,
  input  logic [TIMER_W-1:0] i_k,
  output logic               o_tc
);

  logic [TIMER_W-1:0] r_cnt;
  logic [TIMER_W-1:0] w_term;
  logic               w_hit;

  assign w_term = i_half ? (i_k >> 1) : i_k;
  assign w_hit  = (r_cnt == w_term);
  assign o_tc   = i_en & w_hit;

  // Count while enabled, reload at terminal count, hold at 0 when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/receive.sv
// UART receiver: synchronizes rx, validates the start bit at its mid-point,
// samples data/parity/stop at bit centres and reports the byte with
// ready, parity, framing and overrun status.
module receive
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  receive_if.slave  bus
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic                   w_tmr_en;
  logic                   w_tmr_half;
  logic                   w_tc;
  logic                   w_sample;

  logic [3:0]             r_bitcnt;
  logic [SR_W-1:0]        r_sr;
  logic                   r_armed;

  frame_fmt_t             w_fmt;
  logic [3:0]             w_nsamp;
  logic [SR_W-1:0]        w_just;
  logic [7:0]             w_data;
  logic                   w_par_rx;
  logic                   w_stop;
  logic                   w_perr;

  logic [7:0]             r_data;
  logic                   r_rxrdy;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_ovf;

  assign w_rxs   = r_sync[SYNC_STAGES-1];
  assign w_fmt   = '{eight: bus.eight, parity_en: bus.parity_en, ohel: bus.ohel};
  assign w_nsamp = fmt_samples(w_fmt);

  // Samples sit at the top of the shift register; move them down to bit 0.
  assign w_just   = r_sr >> (4'd10 - w_nsamp);
  assign w_data   = w_fmt.eight ? w_just[7:0] : {1'b0, w_just[6:0]};
  assign w_par_rx = w_just[w_nsamp - 4'd2];
  assign w_stop   = w_just[w_nsamp - 4'd1];
  assign w_perr   = w_fmt.parity_en & (w_par_rx ^ expected_parity(w_data, w_fmt));

  // Metastability synchronizer on the serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx};
    end
  end

  uart_bit_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_tmr_en),
    .i_half (w_tmr_half),
    .i_k    (bus.k),
    .o_tc   (w_tc)
  );

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and bit-timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_en    = 1'b0;
    w_tmr_half  = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxs && r_armed) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_tmr_en   = 1'b1;
        w_tmr_half = 1'b1;
        if (w_tc) begin
          // Still low at mid start bit: genuine start; otherwise a glitch.
          w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        w_tmr_en = 1'b1;
        if (w_tc) begin
          w_sample = 1'b1;
          if (r_bitcnt == (w_nsamp - 4'd1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sample shift register and sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr     <= '0;
      r_bitcnt <= 4'd0;
    end else if (w_sample) begin
      r_sr     <= {w_rxs, r_sr[SR_W-1:1]};
      r_bitcnt <= r_bitcnt + 4'd1;
    end else if (r_state != ST_DATA) begin
      r_bitcnt <= 4'd0;
    end
  end

  // After a framing error the line must return high before a new start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b1;
    end else if ((r_state == ST_DONE) && !w_stop) begin
      r_armed <= 1'b0;
    end else if (w_rxs) begin
      r_armed <= 1'b1;
    end
  end

  // Host-visible byte and status; a completing frame takes priority over read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'd0;
      r_rxrdy <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_data  <= w_data;
      r_rxrdy <= 1'b1;
      r_perr  <= w_perr;
      r_ferr  <= ~w_stop;
      r_ovf   <= r_rxrdy & ~bus.read;
    end else if (bus.read) begin
      r_rxrdy <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign bus.data  = r_data;
  assign bus.rxrdy = r_rxrdy;
  assign bus.perr  = r_perr;
  assign bus.ferr  = r_ferr;
  assign bus.ovf   = r_ovf;

endmodule
